// File: rtl/serial_pattern_tx.sv
// Parallel-in, serial-out frame transmitter: sends Din[L-1:0] MSB-first, one bit
// per Clk, with a valid strobe, a last-bit marker and optional back-to-back repeat.
module serial_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [WIDTH-1:0] Din,
  input  logic [LEN_W-1:0] Len,
  input  logic             Start,
  input  logic             Repeat,
  output logic             Ready,
  output logic             X,
  output logic             Xvalid,
  output logic             Last,
  output logic [CNT_W-1:0] FrameCnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] word_q;   // latched frame, left-aligned so bit L-1 sits at the MSB
  logic [WIDTH-1:0] sh_q;     // bits still to be sent after the current X
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;    // bits remaining after the one currently on X
  logic [LEN_W-1:0] l_eff;
  logic [WIDTH-1:0] din_aligned;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    l_eff = Len;
    if (Len == '0 || Len > WIDTH_L) l_eff = WIDTH_L;
    din_aligned = Din << (WIDTH_L - l_eff);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state    <= IDLE;
      Ready    <= 1'b1;
      X        <= 1'b0;
      Xvalid   <= 1'b0;
      Last     <= 1'b0;
      FrameCnt <= '0;
      word_q   <= '0;
      sh_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state  <= SHIFT;
            Ready  <= 1'b0;
            word_q <= din_aligned;
            len_q  <= l_eff;
            X      <= din_aligned[WIDTH-1];
            sh_q   <= din_aligned << 1;
            cnt_q  <= l_eff - LEN_W'(1);
            Xvalid <= 1'b1;
            Last   <= (l_eff == LEN_W'(1));
          end
        end
        SHIFT: begin
          if (Last) begin
            FrameCnt <= FrameCnt + CNT_W'(1);
            if (Repeat) begin
              // Reload from the latched copy; the live Din/Len ports are ignored.
              X      <= word_q[WIDTH-1];
              sh_q   <= word_q << 1;
              cnt_q  <= len_q - LEN_W'(1);
              Xvalid <= 1'b1;
              Last   <= (len_q == LEN_W'(1));
            end else begin
              state  <= IDLE;
              Ready  <= 1'b1;
              X      <= 1'b0;
              Xvalid <= 1'b0;
              Last   <= 1'b0;
              sh_q   <= '0;
              cnt_q  <= '0;
            end
          end else begin
            X     <= sh_q[WIDTH-1];
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q - LEN_W'(1);
            Last  <= (cnt_q == LEN_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
